// File: rtl/aes_block_packer.sv
// Purpose: packs a byte-serial plaintext stream into 128-bit AES blocks, first byte in the MSB lane.
// Latency: block_valid is registered on the edge that accepts the 16th byte and is visible the next cycle.
// Backpressure: byte_ready drops while a finished block waits; the block is held frozen until block_ready.
module aes_block_packer #(
    // Bytes per block. The datapath is sized for AES-128 and only 16 is supported.
    parameter int NBYTES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic [127:0] block_data,
    output logic         block_valid,
    input  logic         block_ready,
    output logic [4:0]   fill_count
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t         state_q,       state_d;
    logic [127:0]   block_data_q,  block_data_d;
    logic           block_valid_q, block_valid_d;
    logic [4:0]     fill_count_q,  fill_count_d;

    logic           byte_acc;
    logic           handoff;
    logic           last_byte;

    // Ready comes from state and reset only, so it never loops through byte_valid or block_ready.
    assign byte_ready = (state_q == ST_FILL) && !rst;
    assign byte_acc   = byte_valid && byte_ready;
    assign handoff    = block_valid_q && block_ready;
    assign last_byte  = (fill_count_q == 5'(NBYTES - 1));

    // Next-state: clear outranks both handshakes; bytes land in the lane selected by fill_count.
    always_comb begin
        state_d       = state_q;
        block_data_d  = block_data_q;
        block_valid_d = block_valid_q;
        fill_count_d  = fill_count_q;

        if (clear) begin
            // Partial bytes already written into block_data stay there; only the count is dropped.
            state_d       = ST_FILL;
            block_valid_d = 1'b0;
            fill_count_d  = 5'd0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (byte_acc) begin
                        for (int i = 0; i < 16; i++) begin
                            if (fill_count_q[3:0] == 4'(i)) begin
                                block_data_d[127 - 8*i -: 8] = byte_in;
                            end
                        end
                        fill_count_d = fill_count_q + 5'd1;
                        if (last_byte) begin
                            state_d       = ST_FULL;
                            block_valid_d = 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    // block_data is left as-is after handoff so the core can still see it.
                    if (handoff) begin
                        state_d       = ST_FILL;
                        block_valid_d = 1'b0;
                        fill_count_d  = 5'd0;
                    end
                end
                default: begin
                    state_d       = ST_FILL;
                    block_valid_d = 1'b0;
                    fill_count_d  = 5'd0;
                end
            endcase
        end
    end

    // State registers with synchronous reset; reset also zeroes the block register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            block_data_q  <= '0;
            block_valid_q <= 1'b0;
            fill_count_q  <= 5'd0;
        end else begin
            state_q       <= state_d;
            block_data_q  <= block_data_d;
            block_valid_q <= block_valid_d;
            fill_count_q  <= fill_count_d;
        end
    end

    assign block_data  = block_data_q;
    assign block_valid = block_valid_q;
    assign fill_count  = fill_count_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Purpose: randomized and directed stimulus for aes_block_packer against a queue-based reference model.
// Latency: expected blocks are queued when the 16th byte is accepted and popped at each observed handoff.
// Backpressure: block_ready is held low and toggled to exercise the frozen-block and dropped-byte paths.
module tb_aes_block_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic         byte_valid = 1'b0;
    logic         byte_ready;
    logic [127:0] block_data;
    logic         block_valid;
    logic         block_ready = 1'b0;
    logic [4:0]   fill_count;

    int checks = 0;
    int failures = 0;

    aes_block_packer #(.NBYTES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .block_data  (block_data),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .fill_count  (fill_count)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the current block, a pending-block flag, and expected handoffs.
    logic [7:0]   m_cur[$];
    bit           m_full = 1'b0;
    logic [127:0] m_data = '0;
    bit           m_known = 1'b0;
    logic [127:0] exp_q[$];

    int           cyc = 0;
    bit           mon_en = 1'b0;
    int           hcount = 0;
    logic [127:0] last_ho = '0;
    bit           prev_valid = 1'b0;
    int           rise_last = 0;
    int           rise_prev = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model update on each rising edge from the inputs presented during the cycle.
    always @(posedge clk) begin
        logic [127:0] blk;
        cyc++;
        if (rst) begin
            m_cur.delete();
            m_full  = 1'b0;
            m_data  = '0;
            m_known = 1'b1;
            exp_q.delete();
        end else if (clear) begin
            m_cur.delete();
            if (m_full) begin
                m_full = 1'b0;
                void'(exp_q.pop_back());
            end
        end else if (!m_full) begin
            if (byte_valid) begin
                m_cur.push_back(byte_in);
                m_known = 1'b0;
                if (m_cur.size() == 16) begin
                    blk = '0;
                    foreach (m_cur[i]) blk = {blk[119:0], m_cur[i]};
                    m_data  = blk;
                    m_known = 1'b1;
                    m_full  = 1'b1;
                    exp_q.push_back(blk);
                    m_cur.delete();
                end
            end
        end else if (block_ready) begin
            m_full = 1'b0;
        end
    end

    // Monitor on the falling edge: per-cycle outputs against the model, and the handoff scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("byte_ready", 128'(byte_ready), 128'(!m_full && !rst));
            chk("block_valid", 128'(block_valid), 128'(m_full));
            chk("fill_count", 128'(fill_count), m_full ? 128'd16 : 128'(m_cur.size()));
            if (m_known)
                chk("block_data_hold", block_data, m_data);
            if (block_valid && block_ready && !clear && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("handoff_unexpected", 128'd1, 128'd0);
                end else begin
                    chk("block_data_handoff", block_data, exp_q.pop_front());
                end
                hcount++;
                last_ho = block_data;
            end
            if (block_valid && !prev_valid) begin
                rise_prev = rise_last;
                rise_last = cyc;
            end
            prev_valid = block_valid;
        end
    end

    task automatic drv(input logic r, input logic c, input logic bv, input logic [7:0] b, input logic br);
        rst         = r;
        clear       = c;
        byte_valid  = bv;
        byte_in     = b;
        block_ready = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] vec[16];
        int h0;
        int i;
        logic bv;
        vec = '{8'h24, 8'h43, 8'hf6, 8'ha8, 8'h88, 8'h5a, 8'h30, 8'h8d,
                8'h31, 8'h31, 8'h98, 8'ha2, 8'he0, 8'h37, 8'h07, 8'h24};

        // Reset then full-rate stream with block_ready high.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("reset_fill", 128'(fill_count), 128'd0);
        chk("reset_data", block_data, 128'h0);
        chk("reset_valid", 128'(block_valid), 128'd0);
        drv(1, 0, 0, 8'h00, 0);
        for (int k = 0; k < 16; k++) drv(0, 0, 1, vec[k], 1);
        drv(0, 0, 0, 8'h00, 1);
        drv(0, 0, 0, 8'h00, 1);
        chk("t1_handoffs", 128'(hcount), 128'd1);
        chk("t1_block", last_ho, 128'h2443f6a8885a308d313198a2e0370724);

        // Backpressure with 8'hff offered throughout the stall.
        for (int k = 0; k < 16; k++) drv(0, 0, 1, vec[k], 0);
        for (int k = 0; k < 10; k++) drv(0, 0, 1, 8'hff, 0);
        chk("t2_stall_data", block_data, 128'h2443f6a8885a308d313198a2e0370724);
        chk("t2_stall_ready", 128'(byte_ready), 128'd0);
        drv(0, 0, 1, 8'hff, 1);
        chk("t2_handoffs", 128'(hcount), 128'd2);
        drv(0, 0, 1, 8'h5c, 0);
        for (int k = 1; k < 16; k++) drv(0, 0, 1, 8'($urandom), 0);
        drv(0, 0, 0, 8'h00, 1);
        chk("t2_next_first_byte", 128'(last_ho[127:120]), 128'h5c);

        // Gapped input, block_ready toggling while filling.
        i = 0;
        while (i < 16) begin
            bv = 1'($urandom_range(0, 1));
            if (bv) begin
                drv(0, 0, 1, 8'(i), 1'($urandom_range(0, 1)));
                i++;
            end else begin
                drv(0, 0, 0, 8'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        drv(0, 0, 0, 8'h00, 1);
        chk("t3_block", last_ho, 128'h000102030405060708090a0b0c0d0e0f);

        // Clear mid-block with a byte offered in the same cycle.
        for (int k = 0; k < 5; k++) drv(0, 0, 1, 8'($urandom), 1);
        drv(0, 1, 1, 8'haa, 1);
        chk("t4_fill_after_clear", 128'(fill_count), 128'd0);
        for (int k = 0; k < 16; k++) drv(0, 0, 1, 8'(8'h10 + k), 1);
        drv(0, 0, 0, 8'h00, 1);
        chk("t4_block", last_ho, 128'h101112131415161718191a1b1c1d1e1f);

        // Clear while FULL must discard the block; reset mid-block zeroes everything.
        for (int k = 0; k < 16; k++) drv(0, 0, 1, 8'($urandom), 0);
        h0 = hcount;
        drv(0, 1, 0, 8'h00, 1);
        chk("t5_valid_after_clear", 128'(block_valid), 128'd0);
        drv(0, 0, 0, 8'h00, 1);
        drv(0, 0, 0, 8'h00, 1);
        chk("t5_no_handoff", 128'(hcount), 128'(h0));
        for (int k = 0; k < 9; k++) drv(0, 0, 1, 8'($urandom), 1);
        drv(1, 0, 1, 8'h77, 1);
        chk("t5_rst_fill", 128'(fill_count), 128'd0);
        chk("t5_rst_data", block_data, 128'h0);

        // Back-to-back blocks at full rate: 17-cycle period.
        for (int k = 0; k < 40; k++) drv(0, 0, 1, 8'($urandom), 1);
        chk("t6_period", 128'(rise_last - rise_prev), 128'd17);

        // Random traffic with occasional clear and reset.
        for (int k = 0; k < 500; k++) begin
            drv(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        // Drain any pending block.
        for (int k = 0; k < 3; k++) drv(0, 0, 0, 8'h00, 1);
        chk("drain_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Byte-serial front end for the AES encryption top level. Accepts plaintext one byte per handshake and assembles 16 bytes into a 128-bit block, most significant byte first. Presents the completed block to the core with a valid/ready handshake and holds it stable until the core side accepts it. Sits directly upstream of the AES top level and drives its 128-bit `in` port.

## Interface
Parameters:
- `NBYTES`, 16, bytes per block; fixed for AES-128, and no other value is supported.

Ports:
- `clk`  in  1  single clock for the whole block; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `clear`  in  1  synchronous discard of any partial or pending block.
- `byte_in`  in  8  plaintext byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  packer can accept a byte this cycle.
- `block_data`  out  128  assembled block, driven to the AES core input.
- `block_valid`  out  1  `block_data` holds a complete block.
- `block_ready`  in  1  downstream accepts the block this cycle.
- `fill_count`  out  5  bytes held in the current partial block (0..16).

## Operation
- Two states:
  - FILL: collecting bytes.
  - FULL: complete block waiting for handoff.
- Byte accept: occurs when `byte_valid && byte_ready`.
- Block handoff: occurs when `block_valid && block_ready`.
- Byte placement: byte k (0-based, in arrival order) is written to `block_data[127-8k -: 8]`. The first byte goes to [127:120] and the 16th byte to [7:0].
- FILL state:
  - `byte_ready`=1 and `block_valid`=0.
  - Each accepted byte increments `fill_count`.
  - The 16th accept sets `fill_count`=16 and moves to FULL on the same edge.
- FULL state:
  - `byte_ready`=0 and `block_valid`=1.
  - `block_data` stays frozen until handoff.
  - Handoff moves to FILL and sets `fill_count`=0.
  - `block_data` keeps its last value after handoff; it is not cleared.
- No overlap: no byte can be accepted in the same cycle as a handoff, because `byte_ready` is 0 throughout FULL.
- `byte_valid` while `byte_ready`=0: ignored; that byte is not captured.
- `block_ready` while in FILL: ignored.
- Priority order: `rst` > `clear` > handshakes.
- `clear`, in either state:
  - Sets state to FILL and `fill_count`=0. `block_data` is unchanged.
  - A byte presented in the same cycle is dropped.
  - A pending block is discarded without handoff.
- `rst`: sets state to FILL, `fill_count`=0, `block_data`=0.
- `byte_ready` is forced to 0 in any cycle where `rst` is high.

## Timing
- Reset values, from the edge where `rst` is sampled high:
  - `block_valid`=0
  - `fill_count`=0
  - `block_data`=128'h0
  - `byte_ready`=1 from the first cycle after `rst` deasserts
- Latency: `block_valid` rises on the clock edge that accepts the 16th byte. It is visible in the following cycle.
- `block_valid` stays high until the edge where `block_ready` is sampled high, then drops in the following cycle.
- `byte_ready` rises in the cycle after handoff.
- Best-case throughput: 17 cycles per block (16 byte cycles plus 1 handoff cycle).
- Full-rate byte stream: accepted with no bubbles within a block.
- `block_data`, `block_valid` and `fill_count` are registered.
- `byte_ready` is decoded from state and `rst` only. It must not depend on `byte_valid` or `block_ready` (no combinational loop).
- Mid-operation reset: a partial block at any `fill_count` is lost. The next byte after reset becomes byte 0.

## Test plan
- Reset then stream:
  - Stimulus: assert `rst` 2 cycles, then stream bytes 24 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 24 at full rate with `block_ready`=1.
  - Required: `block_valid` high exactly 1 cycle; `block_data`=128'h2443f6a8885a308d313198a2e0370724; `fill_count` steps 0..16 then returns to 0.
- Backpressure:
  - Stimulus: same stream, `block_ready` held 0 for 10 cycles after `block_valid` rises, and `byte_valid`=1 with byte 8'hff throughout.
  - Required: `block_data` unchanged; `byte_ready`=0; 8'hff not captured. After `block_ready` pulses, the next block begins with the next accepted byte at [127:120].
- Gapped input:
  - Stimulus: `byte_valid` toggled randomly, 16 bytes 00..0f.
  - Required: `block_data`=128'h000102030405060708090a0b0c0d0e0f; `fill_count` changes only on accepts.
- Clear mid-block:
  - Stimulus: accept 5 bytes, pulse `clear` with `byte_valid`=1 in the same cycle, then 16 bytes 10..1f.
  - Required: the clear-cycle byte is dropped; `fill_count`=0 after the clear; the result is 128'h101112...1f.
- Clear and reset while FULL:
  - Stimulus: pulse `clear` while FULL with `block_ready`=1.
  - Required: no handoff; `block_valid`=0 in the next cycle.
  - Stimulus: assert `rst` after 9 bytes.
  - Required: `fill_count`=0 and `block_data`=0 in the next cycle.
- Back-to-back blocks:
  - Stimulus: two blocks with `block_ready` tied 1.
  - Required: a 17-cycle period per block; each block matches its input bytes in order.
